// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2^2 SDF FFT stage: state encoding and the
// bit-reversed twiddle-row map used by the twiddle address sequencer.
package fft_pkg;

  localparam logic ST_IDLE_ENC = 1'b0;
  localparam logic ST_RUN_ENC  = 1'b1;

  typedef enum logic {
    ST_IDLE = ST_IDLE_ENC,
    ST_RUN  = ST_RUN_ENC
  } tw_state_t;

  // k for the top two index bits: {0,2,1,3} is n1 bit-reversed.
  function automatic logic [1:0] tw_k_map(input logic [1:0] n1);
    return {n1[0], n1[1]};
  endfunction

endpackage

// File: rtl/fft_dly_line.sv
// Fixed-depth shift register for strobes; DEPTH=0 collapses to a wire so the
// same instance serves registered and unregistered twiddle ROMs.
module fft_dly_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset so no stale strobe can leak out after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/fft_tw_sequencer.sv
// Twiddle ROM address sequencer for one radix-2^2 SDF stage, with valid/sof/eof
// strobes delayed to line up with the ROM output at the complex multiplier.
module fft_tw_sequencer
  import fft_pkg::*;
#(
  parameter int LOG_N = 4,
  parameter int TW_FF = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [LOG_N-1:0] tw_addr,
  output logic             tw_unity,
  output logic             mul_valid,
  output logic             mul_sof,
  output logic             mul_eof,
  output logic             frame_done,
  output logic             sof_err,
  output logic             busy
);

  tw_state_t        state_q, state_d;
  logic [LOG_N-1:0] cnt_q, cnt_d;
  logic             sof_err_q, sof_err_d;
  logic             frame_done_q, frame_done_d;

  logic [LOG_N-1:0] idx;
  logic             accept;
  logic             is_last;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    idx          = in_sof ? '0 : cnt_q;
    accept       = in_valid && (in_sof || (state_q == ST_RUN));
    is_last      = accept && (&idx);
    state_d      = state_q;
    cnt_d        = cnt_q;
    sof_err_d    = sof_err_q;
    frame_done_d = mul_valid && mul_eof;

    if (in_valid && in_sof && (state_q == ST_RUN)) sof_err_d = 1'b1;

    if (accept) begin
      if (is_last) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d   = idx + 1'b1;
        state_d = ST_RUN;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sof_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sof_err_q    <= sof_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Address = k*n2, where k comes from the two MSBs; N=4 has no n2 field.
  if (LOG_N == 2) begin : g_addr_n4
    assign tw_addr = '0;
  end else begin : g_addr
    logic [1:0]       n1;
    logic [LOG_N-3:0] n2;
    assign n1      = idx[LOG_N-1 -: 2];
    assign n2      = idx[LOG_N-3:0];
    assign tw_addr = LOG_N'(tw_k_map(n1)) * LOG_N'(n2);
  end

  fft_dly_line #(
    .WIDTH(4),
    .DEPTH(TW_FF)
  ) u_strobe_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({accept, accept && in_sof, is_last, accept && (tw_addr == '0)}),
    .dout ({mul_valid, mul_sof, mul_eof, tw_unity})
  );

  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
  assign busy       = (state_q == ST_RUN);

endmodule

// File: tb/tb_fft_tw_sequencer.sv
// Bench for fft_tw_sequencer: three configurations (N=16/64 registered ROM,
// N=4 unregistered ROM) checked against a frame-level reference model.
module tb_fft_tw_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // N=16, TW_FF=1
  logic       a_in_valid, a_in_sof;
  logic [3:0] a_tw_addr;
  logic       a_tw_unity, a_mul_valid, a_mul_sof, a_mul_eof, a_frame_done, a_sof_err, a_busy;
  // N=4, TW_FF=0
  logic       b_in_valid, b_in_sof;
  logic [1:0] b_tw_addr;
  logic       b_tw_unity, b_mul_valid, b_mul_sof, b_mul_eof, b_frame_done, b_sof_err, b_busy;
  // N=64, TW_FF=1
  logic       c_in_valid, c_in_sof;
  logic [5:0] c_tw_addr;
  logic       c_tw_unity, c_mul_valid, c_mul_sof, c_mul_eof, c_frame_done, c_sof_err, c_busy;

  fft_tw_sequencer #(.LOG_N(4), .TW_FF(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_sof(a_in_sof),
    .tw_addr(a_tw_addr), .tw_unity(a_tw_unity), .mul_valid(a_mul_valid), .mul_sof(a_mul_sof),
    .mul_eof(a_mul_eof), .frame_done(a_frame_done), .sof_err(a_sof_err), .busy(a_busy));

  fft_tw_sequencer #(.LOG_N(2), .TW_FF(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_sof(b_in_sof),
    .tw_addr(b_tw_addr), .tw_unity(b_tw_unity), .mul_valid(b_mul_valid), .mul_sof(b_mul_sof),
    .mul_eof(b_mul_eof), .frame_done(b_frame_done), .sof_err(b_sof_err), .busy(b_busy));

  fft_tw_sequencer #(.LOG_N(6), .TW_FF(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_sof(c_in_sof),
    .tw_addr(c_tw_addr), .tw_unity(c_tw_unity), .mul_valid(c_mul_valid), .mul_sof(c_mul_sof),
    .mul_eof(c_mul_eof), .frame_done(c_frame_done), .sof_err(c_sof_err), .busy(c_busy));

  // Reference model state for the N=16 instance: position in frame and flags.
  bit m_run;
  int m_cnt;
  bit m_err;
  bit m_prev_last;

  int exp_frame16 [16] = '{0,0,0,0, 0,2,4,6, 0,1,2,3, 0,3,6,9};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Twiddle exponent for sample n of an N=2^logn frame, straight from the k*n2 rule.
  function automatic int ref_addr(input int n, input int logn);
    int q;
    int n1;
    int k;
    q  = 1 << (logn - 2);
    n1 = n / q;
    case (n1)
      0: k = 0;
      1: k = 2;
      2: k = 1;
      default: k = 3;
    endcase
    return k * (n % q);
  endfunction

  // One clock of the N=16 instance; called 1 time unit after a rising edge.
  task automatic a_step(input bit v, input bit s, output logic [3:0] addr_seen);
    int  n;
    bit  acc;
    bit  last;
    n    = s ? 0 : m_cnt;
    acc  = v && (m_run || s);
    last = acc && (n == 15);
    a_in_valid = v;
    a_in_sof   = s;
    @(negedge clk);
    addr_seen = a_tw_addr;
    if (acc) check("a_tw_addr", a_tw_addr, ref_addr(n, 4));
    if (v && s && m_run) m_err = 1'b1;
    if (acc) begin
      if (last) begin
        m_cnt = 0;
        m_run = 1'b0;
      end else begin
        m_cnt = n + 1;
        m_run = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("a_mul_valid", a_mul_valid, acc);
    check("a_mul_sof", a_mul_sof, acc && s);
    check("a_mul_eof", a_mul_eof, last);
    if (acc) check("a_tw_unity", a_tw_unity, ref_addr(n, 4) == 0);
    check("a_frame_done", a_frame_done, m_prev_last);
    check("a_sof_err", a_sof_err, m_err);
    check("a_busy", a_busy, m_run);
    m_prev_last = last;
  endtask

  task automatic a_idle(input int cycles);
    logic [3:0] unused_addr;
    for (int i = 0; i < cycles; i++) a_step(1'b0, 1'b0, unused_addr);
  endtask

  initial begin
    logic [3:0] addr;
    bit         b_run;
    int         b_cnt;
    bit         b_last;
    bit         v;
    bit         s;

    rst_n = 1'b0;
    a_in_valid = 0; a_in_sof = 0;
    b_in_valid = 0; b_in_sof = 0;
    c_in_valid = 0; c_in_sof = 0;
    m_run = 0; m_cnt = 0; m_err = 0; m_prev_last = 0;

    #2;
    check("rst_tw_addr", a_tw_addr, 0);
    check("rst_mul_valid", a_mul_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_sof_err", a_sof_err, 0);
    check("rst_frame_done", a_frame_done, 0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contiguous frame against the literal twiddle table.
    for (int i = 0; i < 16; i++) begin
      a_step(1'b1, i == 0, addr);
      check("frame16_table", addr, exp_frame16[i]);
    end
    a_idle(2);

    // Same frame with a stall every other cycle.
    for (int i = 0; i < 32; i++) a_step(i % 2 == 0, i == 0, addr);
    a_idle(2);

    // Back-to-back frames with no bubble.
    for (int i = 0; i < 32; i++) a_step(1'b1, (i % 16) == 0, addr);
    a_idle(2);
    check("b2b_no_err", a_sof_err, 0);

    // Early sof at index 7 resynchronises the frame.
    for (int i = 0; i < 7; i++) a_step(1'b1, i == 0, addr);
    a_step(1'b1, 1'b1, addr);
    check("resync_err_set", a_sof_err, 1);
    for (int i = 0; i < 15; i++) a_step(1'b1, 1'b0, addr);
    a_idle(2);

    // Reset in the middle of a frame at index 9.
    for (int i = 0; i < 9; i++) a_step(1'b1, i == 0, addr);
    #2 rst_n = 1'b0;
    a_in_valid = 0; a_in_sof = 0;
    #1;
    check("midrst_tw_addr", a_tw_addr, 0);
    check("midrst_mul_valid", a_mul_valid, 0);
    check("midrst_mul_sof", a_mul_sof, 0);
    check("midrst_mul_eof", a_mul_eof, 0);
    check("midrst_tw_unity", a_tw_unity, 0);
    check("midrst_frame_done", a_frame_done, 0);
    check("midrst_sof_err", a_sof_err, 0);
    check("midrst_busy", a_busy, 0);
    m_run = 0; m_cnt = 0; m_err = 0; m_prev_last = 0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) a_step(1'b1, 1'b0, addr);
    for (int i = 0; i < 16; i++) a_step(1'b1, i == 0, addr);
    a_idle(2);

    // Random valid/sof traffic.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 4) != 0;
      s = v && ((($urandom % 24) == 0) || (!m_run && (($urandom % 2) == 0)));
      a_step(v, s, addr);
    end
    a_idle(2);

    // N=4, unregistered ROM: strobes are combinational in the input cycle.
    b_run = 0; b_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      int n;
      bit acc;
      v = ($urandom % 3) != 0;
      s = v && !b_run && (($urandom % 2) == 0);
      n = s ? 0 : b_cnt;
      acc = v && (b_run || s);
      b_last = acc && (n == 3);
      b_in_valid = v;
      b_in_sof = s;
      #1;
      check("b_mul_valid", b_mul_valid, acc);
      check("b_mul_sof", b_mul_sof, acc && s);
      check("b_mul_eof", b_mul_eof, b_last);
      if (acc) check("b_tw_addr", b_tw_addr, ref_addr(n, 2));
      if (acc) begin
        if (b_last) begin b_cnt = 0; b_run = 0; end
        else begin b_cnt = n + 1; b_run = 1; end
      end
      @(posedge clk);
      #1;
      check("b_frame_done", b_frame_done, b_last);
      check("b_busy", b_busy, b_run);
    end
    b_in_valid = 0; b_in_sof = 0;

    // N=64, one contiguous frame; last sample lands on exponent 45.
    for (int i = 0; i < 64; i++) begin
      c_in_valid = 1'b1;
      c_in_sof = (i == 0);
      @(negedge clk);
      check("c_tw_addr", c_tw_addr, ref_addr(i, 6));
      if (i == 63) check("c_addr_last", c_tw_addr, 45);
      @(posedge clk);
      #1;
      check("c_mul_valid", c_mul_valid, 1);
      check("c_mul_eof", c_mul_eof, i == 63);
    end
    c_in_valid = 0; c_in_sof = 0;
    @(posedge clk);
    #1;
    check("c_frame_done", c_frame_done, 1);
    check("c_mul_valid_idle", c_mul_valid, 0);
    check("c_busy_idle", c_busy, 0);
    check("c_sof_err", c_sof_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
